// File: rtl/uart_rx_cfg_ctrl.sv
// uart_rx_cfg_ctrl: owns the UART receiver configuration (Prescale/PAR_EN/PAR_TYP),
// swaps in host-requested settings only after the serial line has been quiet long
// enough, masks the line while the receiver resynchronises, and buffers received
// words in a small FIFO with a valid/ready read port and a sticky overflow flag.
module uart_rx_cfg_ctrl #(
    parameter int   DATA_WIDTH   = 8,
    parameter int   FIFO_DEPTH   = 4,
    parameter int   IDLE_BITS    = 11,
    parameter int   RST_PRESCALE = 8,
    parameter logic RST_PAR_EN   = 1'b1,
    parameter logic RST_PAR_TYP  = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    output logic                  RX_LINE,
    output logic [4:0]            Prescale,
    output logic                  PAR_EN,
    output logic                  PAR_TYP,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  cfg_wr,
    input  logic [4:0]            cfg_prescale,
    input  logic                  cfg_par_en,
    input  logic                  cfg_par_typ,
    output logic                  cfg_busy,
    output logic                  cfg_err,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic                  ovf,
    input  logic                  ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_APPLY  = 2'd1,
        ST_RESYNC = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [9:0]            r_quiet_cnt;
    logic [9:0]            w_quiet_thr;
    logic                  w_quiet;
    logic                  r_pend;
    logic                  w_pend_nxt;
    logic                  w_cfg_ok;
    logic [4:0]            r_pend_prescale;
    logic                  r_pend_par_en;
    logic                  r_pend_par_typ;
    logic [4:0]            r_prescale;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [4:0]            r_rsync_cnt;
    logic                  r_busy;
    logic                  r_err;

    logic [DATA_WIDTH-1:0] r_mem [0:FIFO_DEPTH-1];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [AW:0]           w_wr_nxt;
    logic [AW:0]           w_rd_nxt;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [DATA_WIDTH-1:0] w_head_nxt;
    logic                  r_ovf;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;

    // Quiet threshold follows the active prescale, so a swap rescales the next wait.
    assign w_quiet_thr = 10'(IDLE_BITS) * {5'd0, r_prescale};
    assign w_quiet     = (r_quiet_cnt >= w_quiet_thr);
    assign w_cfg_ok    = cfg_wr & (cfg_prescale >= 5'd4);

    // Line is forced idle whenever the receiver is being reconfigured.
    assign RX_LINE  = (r_state == ST_RUN) ? RX_IN : 1'b1;
    assign Prescale = r_prescale;
    assign PAR_EN   = r_par_en;
    assign PAR_TYP  = r_par_typ;
    assign cfg_busy = r_busy;
    assign cfg_err  = r_err;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign ovf      = r_ovf;

    // Next-state selection for the configuration sequencer and the pending flag.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (r_pend && w_quiet) begin
                    w_state_nxt = ST_APPLY;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_APPLY: w_state_nxt = ST_RESYNC;
            ST_RESYNC: begin
                if (r_rsync_cnt == (r_prescale - 5'd1)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_RESYNC;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
        // A fresh write always wins, even in the cycle the old one is consumed.
        if (w_cfg_ok) begin
            w_pend_nxt = 1'b1;
        end else if (r_state == ST_APPLY) begin
            w_pend_nxt = 1'b0;
        end else begin
            w_pend_nxt = r_pend;
        end
    end

    // Sequencer state, quiet-line counter, pending and active configuration registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state         <= ST_RUN;
            r_quiet_cnt     <= 10'd0;
            r_pend          <= 1'b0;
            r_pend_prescale <= 5'(RST_PRESCALE);
            r_pend_par_en   <= RST_PAR_EN;
            r_pend_par_typ  <= RST_PAR_TYP;
            r_prescale      <= 5'(RST_PRESCALE);
            r_par_en        <= RST_PAR_EN;
            r_par_typ       <= RST_PAR_TYP;
            r_rsync_cnt     <= 5'd0;
            r_busy          <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_busy  <= w_pend_nxt | (w_state_nxt != ST_RUN);
            r_err   <= cfg_wr & (cfg_prescale < 5'd4);
            if (!RX_IN) begin
                r_quiet_cnt <= 10'd0;
            end else if (r_quiet_cnt != 10'd1023) begin
                r_quiet_cnt <= r_quiet_cnt + 10'd1;
            end
            if (w_cfg_ok) begin
                r_pend_prescale <= cfg_prescale;
                r_pend_par_en   <= cfg_par_en;
                r_pend_par_typ  <= cfg_par_typ;
            end
            if (r_state == ST_APPLY) begin
                r_prescale  <= r_pend_prescale;
                r_par_en    <= r_pend_par_en;
                r_par_typ   <= r_pend_par_typ;
                r_rsync_cnt <= 5'd0;
            end else if (r_state == ST_RESYNC) begin
                r_rsync_cnt <= r_rsync_cnt + 5'd1;
            end
        end
    end

    // FIFO handshake decode, next pointers and the next head word.
    always_comb begin
        w_full = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_pop  = r_rd_valid & rd_ready;
        w_push = data_valid & (~w_full | w_pop);
        w_drop = data_valid & w_full & ~w_pop;
        w_wr_nxt = r_wr_ptr;
        w_rd_nxt = r_rd_ptr;
        if (w_push) begin
            w_wr_nxt = r_wr_ptr + 1'b1;
        end else begin
            w_wr_nxt = r_wr_ptr;
        end
        if (w_pop) begin
            w_rd_nxt = r_rd_ptr + 1'b1;
        end else begin
            w_rd_nxt = r_rd_ptr;
        end
        // Word landing in the slot that becomes head bypasses the storage array.
        if (w_push && (w_rd_nxt == r_wr_ptr)) begin
            w_head_nxt = P_DATA;
        end else begin
            w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
        end
    end

    // FIFO storage array; contents need no reset because pointers qualify them.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= P_DATA;
        end
    end

    // FIFO pointers, registered read port and sticky overflow flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_rd_valid <= (w_wr_nxt != w_rd_nxt);
            if (w_wr_nxt != w_rd_nxt) begin
                r_rd_data <= w_head_nxt;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg_ctrl.sv
// Self-checking bench for uart_rx_cfg_ctrl: received words go through a scoreboard
// queue; configuration sequencing is checked against cycle counts derived from
// the quiet threshold (IDLE_BITS * Prescale) and the resync length.
module tb_uart_rx_cfg_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b0;
    logic       RX_LINE;
    logic [4:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       data_valid = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       cfg_wr = 1'b0;
    logic [4:0] cfg_prescale = 5'd0;
    logic       cfg_par_en = 1'b0;
    logic       cfg_par_typ = 1'b0;
    logic       cfg_busy;
    logic       cfg_err;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready = 1'b0;
    logic       ovf;
    logic       ovf_clr = 1'b0;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] sb_q[$];
    logic [7:0] exp_w;

    uart_rx_cfg_ctrl dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .RX_LINE(RX_LINE),
        .Prescale(Prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .data_valid(data_valid), .P_DATA(P_DATA),
        .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en),
        .cfg_par_typ(cfg_par_typ), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 CLK = ~CLK;

    task automatic test_reset();
        RST = 1'b0; RX_IN = 1'b0;
        #12;
        n_checks++; if (Prescale !== 5'd8) begin n_fail++; $display("FAIL reset_prescale got %0d exp 8", Prescale); end
        n_checks++; if (PAR_EN !== 1'b1) begin n_fail++; $display("FAIL reset_par_en got %b exp 1", PAR_EN); end
        n_checks++; if (PAR_TYP !== 1'b0) begin n_fail++; $display("FAIL reset_par_typ got %b exp 0", PAR_TYP); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", ovf); end
        n_checks++; if (cfg_busy !== 1'b0 || cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg got busy=%b err=%b exp 0/0", cfg_busy, cfg_err); end
        n_checks++; if (RX_LINE !== 1'b0) begin n_fail++; $display("FAIL reset_rx_line_lo got %b exp 0", RX_LINE); end
        RX_IN = 1'b1;
        #1;
        n_checks++; if (RX_LINE !== 1'b1) begin n_fail++; $display("FAIL reset_rx_line_hi got %b exp 1", RX_LINE); end
        @(negedge CLK);
        RST = 1'b1; RX_IN = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_order();
        logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};
        rd_ready = 1'b1;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL order_idle_valid got %b exp 0", rd_valid); end
        for (int i = 0; i < 3; i++) begin
            data_valid = 1'b1; P_DATA = words[i];
            sb_q.push_back(words[i]);
            @(negedge CLK);
            exp_w = sb_q.pop_front();
            n_checks++; if (rd_valid !== 1'b1 || rd_data !== exp_w) begin n_fail++; $display("FAIL order_word%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid, rd_data, exp_w); end
        end
        data_valid = 1'b0;
        @(negedge CLK);
        n_checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h33) begin n_fail++; $display("FAIL order_drained got v=%b d=%h exp v=0 d=33", rd_valid, rd_data); end
        rd_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int model_cnt = 0;
        logic model_ovf = 1'b0;
        int guard = 0;
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_valid = 1'b1; P_DATA = 8'h40 + 8'(i);
            if (model_cnt < 4) begin sb_q.push_back(P_DATA); model_cnt++; end
            else model_ovf = 1'b1;
            @(negedge CLK);
        end
        data_valid = 1'b0;
        @(negedge CLK);
        n_checks++; if (ovf !== model_ovf) begin n_fail++; $display("FAIL ovf_set got %b exp %b", ovf, model_ovf); end
        ovf_clr = 1'b1;
        @(negedge CLK);
        ovf_clr = 1'b0;
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", ovf); end
        rd_ready = 1'b1;
        while (sb_q.size() > 0 && guard < 20) begin
            exp_w = sb_q.pop_front();
            n_checks++; if (rd_valid !== 1'b1 || rd_data !== exp_w) begin n_fail++; $display("FAIL ovf_drain got v=%b d=%h exp v=1 d=%h", rd_valid, rd_data, exp_w); end
            @(negedge CLK);
            guard++;
        end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %b exp 0 (5th word kept?)", rd_valid); end
        rd_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        int n = 0;
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_valid = 1'b1; P_DATA = 8'hA0 + 8'(i);
            sb_q.push_back(P_DATA);
            @(negedge CLK);
        end
        data_valid = 1'b1; P_DATA = 8'hA4; rd_ready = 1'b1;
        exp_w = sb_q.pop_front();
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== exp_w) begin n_fail++; $display("FAIL full_head got v=%b d=%h exp v=1 d=%h", rd_valid, rd_data, exp_w); end
        sb_q.push_back(8'hA4);
        @(negedge CLK);
        data_valid = 1'b0; rd_ready = 1'b0;
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_ovf got %b exp 0", ovf); end
        data_valid = 1'b1; P_DATA = 8'hEE; ovf_clr = 1'b1;
        @(negedge CLK);
        data_valid = 1'b0; ovf_clr = 1'b0;
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_clr_vs_drop got %b exp 1", ovf); end
        ovf_clr = 1'b1;
        @(negedge CLK);
        ovf_clr = 1'b0;
        rd_ready = 1'b1;
        while (rd_valid === 1'b1 && n < 10) begin
            exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hXX;
            n_checks++; if (rd_data !== exp_w) begin n_fail++; $display("FAIL full_drain got %h exp %h", rd_data, exp_w); end
            n++;
            @(negedge CLK);
        end
        rd_ready = 1'b0;
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL full_count got %0d exp 4", n); end
        sb_q.delete();
    endtask

    task automatic test_cfg_swap();
        int cnt = 0;
        RX_IN = 1'b0;
        cfg_wr = 1'b1; cfg_prescale = 5'd16; cfg_par_en = 1'b0; cfg_par_typ = 1'b1;
        @(negedge CLK);
        cfg_wr = 1'b0;
        n_checks++; if (cfg_busy !== 1'b1 || Prescale !== 5'd8) begin n_fail++; $display("FAIL cfg_pending got busy=%b p=%0d exp 1/8", cfg_busy, Prescale); end
        for (int i = 0; i < 30; i++) begin
            RX_IN = (i % 3 != 2);
            @(negedge CLK);
        end
        n_checks++; if (cfg_busy !== 1'b1 || Prescale !== 5'd8) begin n_fail++; $display("FAIL cfg_toggle got busy=%b p=%0d exp 1/8", cfg_busy, Prescale); end
        RX_IN = 1'b0;
        @(negedge CLK);
        // 88 high edges fill the quiet counter, one more enters APPLY, one more loads.
        RX_IN = 1'b1;
        while (Prescale !== 5'd16 && cnt < 200) begin
            @(negedge CLK);
            cnt++;
        end
        n_checks++; if (cnt !== 90) begin n_fail++; $display("FAIL cfg_apply_latency got %0d exp 90", cnt); end
        n_checks++; if (PAR_EN !== 1'b0 || PAR_TYP !== 1'b1 || cfg_busy !== 1'b1) begin n_fail++; $display("FAIL cfg_applied got en=%b typ=%b busy=%b exp 0/1/1", PAR_EN, PAR_TYP, cfg_busy); end
        RX_IN = 1'b0;
        cnt = 0;
        while (RX_LINE === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge CLK);
        end
        n_checks++; if (cnt !== 16) begin n_fail++; $display("FAIL cfg_resync_len got %0d exp 16", cnt); end
        n_checks++; if (cfg_busy !== 1'b0 || Prescale !== 5'd16) begin n_fail++; $display("FAIL cfg_done got busy=%b p=%0d exp 0/16", cfg_busy, Prescale); end
    endtask

    task automatic test_err_and_reset();
        int cnt = 0;
        cfg_wr = 1'b1; cfg_prescale = 5'd2; cfg_par_en = 1'b1; cfg_par_typ = 1'b0;
        @(negedge CLK);
        cfg_wr = 1'b0;
        n_checks++; if (cfg_err !== 1'b1 || cfg_busy !== 1'b0 || Prescale !== 5'd16) begin n_fail++; $display("FAIL cfg_err_pulse got err=%b busy=%b p=%0d exp 1/0/16", cfg_err, cfg_busy, Prescale); end
        @(negedge CLK);
        n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_1cyc got %b exp 0", cfg_err); end
        data_valid = 1'b1; P_DATA = 8'h5A;
        cfg_wr = 1'b1; cfg_prescale = 5'd5;
        @(negedge CLK);
        data_valid = 1'b0; cfg_wr = 1'b0;
        RX_IN = 1'b1;
        while (Prescale !== 5'd5 && cnt < 400) begin
            @(negedge CLK);
            cnt++;
        end
        n_checks++; if (Prescale !== 5'd5 || rd_valid !== 1'b1) begin n_fail++; $display("FAIL rst_setup got p=%0d v=%b exp 5/1", Prescale, rd_valid); end
        cfg_wr = 1'b1; cfg_prescale = 5'd20;
        @(negedge CLK);
        cfg_wr = 1'b0; RX_IN = 1'b0;
        #2 RST = 1'b0;
        #1;
        n_checks++; if (Prescale !== 5'd8 || PAR_EN !== 1'b1 || PAR_TYP !== 1'b0) begin n_fail++; $display("FAIL rst_mid_cfg got p=%0d en=%b typ=%b exp 8/1/0", Prescale, PAR_EN, PAR_TYP); end
        n_checks++; if (RX_LINE !== 1'b0 || cfg_busy !== 1'b0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state got line=%b busy=%b v=%b exp 0/0/0", RX_LINE, cfg_busy, rd_valid); end
        @(negedge CLK);
        RST = 1'b1; RX_IN = 1'b1;
        repeat (100) @(negedge CLK);
        n_checks++; if (Prescale !== 5'd8 || cfg_busy !== 1'b0) begin n_fail++; $display("FAIL rst_pend_lost got p=%0d busy=%b exp 8/0", Prescale, cfg_busy); end
    endtask

    initial begin
        test_reset();
        test_order();
        test_overflow();
        test_full_push_pop();
        test_cfg_swap();
        test_err_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
